ssemi_decim_strobe_scheduler: RTL and testbench

Sequencer for the decimation cascade. It turns one fast input clock into a chain of per-stage rate strobes: stage k fires on every R_k-th strobe of stage k-1. It takes runtime ratio configuration through a valid/ready handshake, issues a synchronous counter reset to the stage rate logic on start, and holds the output-valid gate low until the cascade has settled. It sits between the AFE/ADC control registers and the CIC/half-band/FIR decimation stages.

---
 rtl/ssemi_decim_strobe_scheduler_pkg.sv | 19 +
 rtl/ssemi_strobe_counter.sv | 43 ++++
 rtl/ssemi_decim_strobe_scheduler.sv | 147 ++++++++++++++
 tb/tb_ssemi_decim_strobe_scheduler.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ssemi_decim_strobe_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// ssemi_decim_strobe_scheduler_pkg : shared encodings for the decimation strobe scheduler | Rev 1.0
// ============================================================================
package ssemi_decim_strobe_scheduler_pkg;

  localparam int SSEMI_SCHED_MAX_STAGES   = 4;
  localparam int SSEMI_SCHED_RATIO_W_DEF  = 4;
  localparam int SSEMI_SCHED_SETTLE_W_DEF = 8;

  typedef enum logic [1:0] {
    SSEMI_SCHED_IDLE   = 2'd0,
    SSEMI_SCHED_SYNC   = 2'd1,
    SSEMI_SCHED_SETTLE = 2'd2,
    SSEMI_SCHED_RUN    = 2'd3
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/ssemi_strobe_counter.sv
`default_nettype none
// ============================================================================
// ssemi_strobe_counter : one cascade stage, fires on every i_ratio-th parent strobe | Rev 1.0
// ============================================================================
module ssemi_strobe_counter
  import ssemi_decim_strobe_scheduler_pkg::*;
#(
  parameter int RATIO_W = SSEMI_SCHED_RATIO_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_parent,
  input  logic [RATIO_W-1:0] i_ratio,
  input  logic               i_clear,
  input  logic               i_enable,
  output logic               o_strobe
);

  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic               strobe;

  assign strobe   = i_enable && i_parent && (cnt_q == i_ratio - RATIO_W'(1));
  assign o_strobe = strobe;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && i_parent) begin
      cnt_d = strobe ? '0 : cnt_q + RATIO_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssemi_decim_strobe_scheduler.sv
`default_nettype none
// ============================================================================
// ssemi_decim_strobe_scheduler : config handshake, start/settle FSM and cascaded rate strobes | Rev 1.0
// ============================================================================
module ssemi_decim_strobe_scheduler
  import ssemi_decim_strobe_scheduler_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int RATIO_W    = SSEMI_SCHED_RATIO_W_DEF,
  parameter int SETTLE_W   = SSEMI_SCHED_SETTLE_W_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_cfg_valid,
  output logic                          o_cfg_ready,
  input  logic [NUM_STAGES*RATIO_W-1:0] i_cfg_ratio,
  input  logic [SETTLE_W-1:0]           i_cfg_settle,
  input  logic                          i_start,
  input  logic                          i_stop,
  output logic [NUM_STAGES-1:0]         o_stage_en,
  output logic                          o_sync_reset,
  output logic                          o_busy,
  output logic                          o_out_valid_gate,
  output logic                          o_cfg_err,
  output logic [1:0]                    o_state
);

  sched_state_e                  state_q, state_d;
  logic [NUM_STAGES*RATIO_W-1:0] ratio_q, ratio_d;
  logic [SETTLE_W-1:0]           settle_q, settle_d;
  logic [SETTLE_W-1:0]           settle_cnt_q, settle_cnt_d;
  logic                          cfg_loaded_q, cfg_loaded_d;
  logic                          cfg_err_q, cfg_err_d;

  logic [NUM_STAGES-1:0] parent;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  is_idle, cnt_en, cnt_clr, ratios_ok, final_strobe;

  assign is_idle      = (state_q == SSEMI_SCHED_IDLE);
  assign cnt_en       = (state_q == SSEMI_SCHED_SETTLE) || (state_q == SSEMI_SCHED_RUN);
  assign cnt_clr      = is_idle || (state_q == SSEMI_SCHED_SYNC) || i_stop;
  assign final_strobe = stage_en[NUM_STAGES-1];

  always_comb begin
    ratios_ok = 1'b1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (i_cfg_ratio[k*RATIO_W +: RATIO_W] == '0) ratios_ok = 1'b0;
    end
  end

  // Configuration wins over start in IDLE; stop suppresses start.
  always_comb begin
    state_d      = state_q;
    ratio_d      = ratio_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    cfg_loaded_d = cfg_loaded_q;
    cfg_err_d    = 1'b0;
    case (state_q)
      SSEMI_SCHED_IDLE: begin
        settle_cnt_d = '0;
        if (i_cfg_valid) begin
          if (ratios_ok) begin
            ratio_d      = i_cfg_ratio;
            settle_d     = i_cfg_settle;
            cfg_loaded_d = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end else if (i_start && !i_stop) begin
          if (cfg_loaded_q) state_d = SSEMI_SCHED_SYNC;
          else              cfg_err_d = 1'b1;
        end
      end
      SSEMI_SCHED_SYNC: begin
        settle_cnt_d = '0;
        if (i_stop)                state_d = SSEMI_SCHED_IDLE;
        else if (settle_q == '0)   state_d = SSEMI_SCHED_RUN;
        else                       state_d = SSEMI_SCHED_SETTLE;
      end
      SSEMI_SCHED_SETTLE: begin
        if (i_stop) begin
          state_d      = SSEMI_SCHED_IDLE;
          settle_cnt_d = '0;
        end else if (final_strobe) begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
          if (settle_cnt_q == settle_q - SETTLE_W'(1)) state_d = SSEMI_SCHED_RUN;
        end
      end
      SSEMI_SCHED_RUN: begin
        if (i_stop) begin
          state_d      = SSEMI_SCHED_IDLE;
          settle_cnt_d = '0;
        end
      end
      default: state_d = SSEMI_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= SSEMI_SCHED_IDLE;
      ratio_q      <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      cfg_loaded_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      cfg_loaded_q <= cfg_loaded_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_root
      assign parent[k] = 1'b1;
    end else begin : g_chain
      assign parent[k] = stage_en[k-1];
    end

    ssemi_strobe_counter #(
      .RATIO_W (RATIO_W)
    ) u_strobe_counter (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_parent (parent[k]),
      .i_ratio  (ratio_q[k*RATIO_W +: RATIO_W]),
      .i_clear  (cnt_clr),
      .i_enable (cnt_en),
      .o_strobe (stage_en[k])
    );
  end

  assign o_stage_en       = stage_en;
  assign o_cfg_ready      = is_idle;
  assign o_busy           = !is_idle;
  assign o_out_valid_gate = (state_q == SSEMI_SCHED_RUN);
  assign o_sync_reset     = (state_q == SSEMI_SCHED_SYNC);
  assign o_cfg_err        = cfg_err_q;
  assign o_state          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ssemi_decim_strobe_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ssemi_decim_strobe_scheduler : vector table plus formula-driven run sequences | Rev 1.0
// ============================================================================
module tb_ssemi_decim_strobe_scheduler;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [11:0] cfg_ratio;
  logic [7:0]  cfg_settle;
  logic        start;
  logic        stop;
  logic [2:0]  stage_en;
  logic        sync_reset;
  logic        busy;
  logic        gate;
  logic        cfg_err;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] en;
    logic       sync;
    logic       busy;
    logic       gate;
    logic       err;
    logic       ready;
    logic [1:0] state;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        cfg_valid;
    logic [11:0] ratio;
    logic [7:0]  settle;
    logic        start;
    logic        stop;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];

  ssemi_decim_strobe_scheduler #(
    .NUM_STAGES (3),
    .RATIO_W    (4),
    .SETTLE_W   (8)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_cfg_valid      (cfg_valid),
    .o_cfg_ready      (cfg_ready),
    .i_cfg_ratio      (cfg_ratio),
    .i_cfg_settle     (cfg_settle),
    .i_start          (start),
    .i_stop           (stop),
    .o_stage_en       (stage_en),
    .o_sync_reset     (sync_reset),
    .o_busy           (busy),
    .o_out_valid_gate (gate),
    .o_cfg_err        (cfg_err),
    .o_state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [2:0] en, logic sy, logic bz, logic gt, logic er, logic rd,
                              logic [1:0] st);
    exp_t e;
    e.en = en; e.sync = sy; e.busy = bz; e.gate = gt; e.err = er; e.ready = rd; e.state = st;
    return e;
  endfunction

  function automatic vec_t mv(string nm, logic r, logic cv, logic [11:0] ra, logic [7:0] se,
                              logic sa, logic so, exp_t e);
    vec_t v;
    v.name = nm; v.rst = r; v.cfg_valid = cv; v.ratio = ra; v.settle = se;
    v.start = sa; v.stop = so; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic r, input logic cv, input logic [11:0] ra, input logic [7:0] se,
                       input logic sa, input logic so);
    rst = r; cfg_valid = cv; cfg_ratio = ra; cfg_settle = se; start = sa; stop = so;
  endtask

  // Expectation is queued with the stimulus and checked against what the DUT shows after the edge.
  task automatic step(input string name, input exp_t e);
    exp_t got;
    exp_t want;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {stage_en, sync_reset, busy, gate, cfg_err, cfg_ready, state};
    want = sb_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got en=%b sync=%b busy=%b gate=%b err=%b ready=%b state=%0d want en=%b sync=%b busy=%b gate=%b err=%b ready=%b state=%0d",
               name, got.en, got.sync, got.busy, got.gate, got.err, got.ready, got.state,
               want.en, want.sync, want.busy, want.gate, want.err, want.ready, want.state);
    end
  endtask

  // Start at n=1; expected strobes follow first = 1+prod(R0..Rk), period prod(R0..Rk).
  task automatic run_seq(input string nm, input int r0, input int r1, input int r2, input int st,
                         input int ncyc, input int stop_n, input bit hold_cfg);
    int   p[3];
    int   run_n;
    exp_t e;
    p[0]  = r0;
    p[1]  = r0 * r1;
    p[2]  = r0 * r1 * r2;
    run_n = (st == 0) ? 2 : 2 + st * p[2];
    for (int n = 1; n <= ncyc; n++) begin
      drive(1'b0, hold_cfg && (n > 1), hold_cfg ? 12'h111 : 12'h000, 8'd0, n == 1, n == stop_n);
      if (n == stop_n) begin
        e = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
      end else begin
        for (int k = 0; k < 3; k++)
          e.en[k] = (n >= 2) && ((n - 1) >= p[k]) && (((n - 1) % p[k]) == 0);
        e.sync  = (n == 1);
        e.busy  = 1'b1;
        e.gate  = (n >= run_n);
        e.err   = 1'b0;
        e.ready = 1'b0;
        e.state = (n == 1) ? 2'd1 : (n < run_n) ? 2'd2 : 2'd3;
      end
      step(nm, e);
    end
    drive(1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t idle_e;
    exp_t idle_err;
    idle_e   = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    idle_err = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);

    vecs[0] = mv("reset",          1'b1, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0, idle_e);
    vecs[1] = mv("start_no_cfg",   1'b0, 1'b0, 12'h000, 8'd0, 1'b1, 1'b0, idle_err);
    vecs[2] = mv("err_one_cycle",  1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0, idle_e);
    vecs[3] = mv("illegal_cfg",    1'b0, 1'b1, 12'h202, 8'd2, 1'b0, 1'b0, idle_err);
    vecs[4] = mv("idle_after_bad", 1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0, idle_e);
    vecs[5] = mv("start_bad_cfg",  1'b0, 1'b0, 12'h000, 8'd0, 1'b1, 1'b0, idle_err);
    vecs[6] = mv("stop_over_start",1'b0, 1'b0, 12'h000, 8'd0, 1'b1, 1'b1, idle_e);
    vecs[7] = mv("cfg_over_start", 1'b0, 1'b1, 12'h222, 8'd2, 1'b1, 1'b0, idle_e);
    vecs[8] = mv("idle_loaded",    1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0, idle_e);

    drive(1'b1, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].cfg_valid, vecs[i].ratio, vecs[i].settle, vecs[i].start,
            vecs[i].stop);
      step(vecs[i].name, vecs[i].exp);
    end

    // Nominal 2,2,2 settle=2 with a bogus config offered throughout the run.
    run_seq("nominal_222", 2, 2, 2, 2, 24, 24, 1'b1);
    run_seq("stop_settle", 2, 2, 2, 2, 10, 10, 1'b0);
    run_seq("restart",     2, 2, 2, 2, 10, 10, 1'b0);

    drive(1'b0, 1'b1, 12'h131, 8'd0, 1'b0, 1'b0);
    step("load_131", idle_e);
    run_seq("passthru_131", 1, 3, 1, 0, 12, 12, 1'b0);

    run_seq("pre_reset", 1, 3, 1, 0, 5, 0, 1'b0);
    drive(1'b1, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0);
    step("mid_reset", idle_e);
    drive(1'b0, 1'b0, 12'h000, 8'd0, 1'b1, 1'b0);
    step("start_after_reset", idle_err);
    drive(1'b0, 1'b0, 12'h000, 8'd0, 1'b0, 1'b0);
    step("idle_after_reset", idle_e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
